// File: rtl/dcache_data_store.sv
// dcache_data_store
//   Set-associative data store and access controller for the data cache.
//   It sits between the datapath request port (dREN/dWEN) and the memory
//   arbiter. It handles hits combinationally and refills a missing block one
//   word at a time. A dirty victim is first pushed to the write buffer.
//   Replacement uses a round-robin pointer per set. A halt-time flush writes
//   back every dirty line and then raises flushed.
//
//   Parameters : WAYS (associativity), SETS (sets per way), WORDS (words/block)
//   Ports      : CLK, RST (sync, active-high)
//                dREN, dWEN, daddr, dstore  -> datapath request
//                hit, ddata                 <- request serviced / read data
//                halt, flushed              -> flush request / completion
//                dmissREN, rdaddr, dwait, dload      -> fill read channel
//                ddirtyWEN, ddirtyaddr, ddirtydata, full -> writeback channel
//   Optional   : define DS_HIT_COUNTER_EN to add output hitcount[31:0].
//                It counts IDLE cycles that hit.
module dcache_data_store #(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  input  logic        dwait,
  input  logic [31:0] dload,
  input  logic        full,
  output logic        hit,
  output logic [31:0] ddata,
  output logic        dmissREN,
  output logic [31:0] rdaddr,
  output logic        ddirtyWEN,
  output logic [31:0] ddirtyaddr,
  output logic [31:0] ddirtydata,
  output logic        flushed
`ifdef DS_HIT_COUNTER_EN
  ,
  output logic [31:0] hitcount
`endif
);

  localparam int WAYB  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SETB  = $clog2(SETS);
  localparam int WORDB = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WOFF  = $clog2(WORDS);
  localparam int TAGW  = 30 - WOFF - SETB;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WB     = 3'd1;
  localparam logic [2:0] FILL   = 3'd2;
  localparam logic [2:0] FLUSH  = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  logic [31:0]      datamem  [WAYS][SETS][WORDS];
  logic [TAGW-1:0]  tagmem   [WAYS][SETS];
  logic [SETS-1:0]  validmem [WAYS];
  logic [SETS-1:0]  dirtymem [WAYS];
  logic [WAYB-1:0]  ptrmem   [SETS];

  logic [2:0]       state;
  logic [WORDB-1:0] k;
  logic [WAYB-1:0]  vway;
  logic [SETB-1:0]  fset;
  logic [WAYB-1:0]  fway;

  logic [TAGW-1:0]  rtag;
  logic [SETB-1:0]  ridx;
  logic [WORDB-1:0] rword;
  logic             req, matchany, klast, fdirty, wbactive, fadvance;
  logic [WAYB-1:0]  mway, vsel, wbway;
  logic [SETB-1:0]  wbset;
  logic             unusedbits;

  assign unusedbits = ^daddr[1:0];

  // Rebuild a word address from its tag, index and word-in-block fields.
  function automatic logic [31:0] mkaddr(input logic [TAGW-1:0] t,
                                         input logic [SETB-1:0] s,
                                         input logic [WORDB-1:0] w);
    logic [31:0] a;
    a = (32'(t) << (2 + WOFF + SETB)) | (32'(s) << (2 + WOFF));
    if (WORDS > 1) a = a | (32'(w) << 2);
    return a;
  endfunction

  assign rtag  = daddr[31 -: TAGW];
  assign ridx  = daddr[2 + WOFF +: SETB];
  assign rword = (WORDS > 1) ? daddr[2 +: WORDB] : '0;
  assign req   = dREN | dWEN;
  assign klast = (k == WORDB'(WORDS - 1));

  // Tag compare across all ways. The victim is the lowest invalid way. When
  // every way is valid, the victim falls back to the set's pointer.
  always_comb begin
    matchany = 1'b0;
    mway     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (validmem[w][ridx] && (tagmem[w][ridx] == rtag)) begin
        matchany = 1'b1;
        mway     = WAYB'(w);
      end
    end
    vsel = ptrmem[ridx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!validmem[w][ridx]) vsel = WAYB'(w);
    end
  end

  // Writeback and flush share the push channel. WB drains the latched victim
  // in the requested set. FLUSH drains the line under the scan counters.
  always_comb begin
    fdirty     = validmem[fway][fset] && dirtymem[fway][fset];
    wbactive   = (state == WB) || ((state == FLUSH) && fdirty);
    wbway      = (state == WB) ? vway : fway;
    wbset      = (state == WB) ? ridx : fset;
    fadvance   = (state == FLUSH) && (!fdirty || (!full && klast));
    hit        = (state == IDLE) && !halt && req && matchany;
    ddata      = (hit && dREN) ? datamem[mway][ridx][rword] : 32'd0;
    dmissREN   = (state == FILL);
    rdaddr     = dmissREN ? mkaddr(rtag, ridx, k) : 32'd0;
    ddirtyWEN  = wbactive;
    ddirtyaddr = wbactive ? mkaddr(tagmem[wbway][wbset], wbset, k) : 32'd0;
    ddirtydata = wbactive ? datamem[wbway][wbset][k] : 32'd0;
    flushed    = (state == HALTED);
  end

  // Control FSM and line metadata. A reset abandons any transfer in flight
  // and invalidates every line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      k     <= '0;
      vway  <= '0;
      fset  <= '0;
      fway  <= '0;
      for (int w = 0; w < WAYS; w++) begin
        validmem[w] <= '0;
        dirtymem[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) ptrmem[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            state <= FLUSH;
            fset  <= '0;
            fway  <= '0;
            k     <= '0;
          end else if (req) begin
            if (matchany) begin
              if (dWEN) dirtymem[mway][ridx] <= 1'b1;
            end else begin
              vway  <= vsel;
              k     <= '0;
              state <= (validmem[vsel][ridx] && dirtymem[vsel][ridx]) ? WB : FILL;
            end
          end
        end
        WB: begin
          if (!full) begin
            k <= klast ? '0 : k + 1'b1;
            if (klast) state <= FILL;
          end
        end
        FILL: begin
          if (!dwait) begin
            k <= klast ? '0 : k + 1'b1;
            if (klast) begin
              validmem[vway][ridx] <= 1'b1;
              dirtymem[vway][ridx] <= 1'b0;
              tagmem[vway][ridx]   <= rtag;
              ptrmem[ridx] <= (ptrmem[ridx] == WAYB'(WAYS - 1)) ? '0 : ptrmem[ridx] + 1'b1;
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (fdirty && !full) begin
            k <= klast ? '0 : k + 1'b1;
            if (klast) dirtymem[fway][fset] <= 1'b0;
          end
          // Scan order is set-major, ways within a set.
          if (fadvance) begin
            if (fway == WAYB'(WAYS - 1)) begin
              fway <= '0;
              if (fset == SETB'(SETS - 1)) state <= HALTED;
              else fset <= fset + 1'b1;
            end else begin
              fway <= fway + 1'b1;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // Data words carry no reset. A line is unreadable until it is refilled
  // and marked valid.
  always_ff @(posedge CLK) begin
    if ((state == IDLE) && !halt && dWEN && matchany)
      datamem[mway][ridx][rword] <= dstore;
    else if ((state == FILL) && !dwait)
      datamem[vway][ridx][k] <= dload;
  end

`ifdef DS_HIT_COUNTER_EN
  // Hits occur only in IDLE, so the count holds still once the cache halts.
  always_ff @(posedge CLK) begin
    if (RST) hitcount <= 32'd0;
    else if (hit) hitcount <= hitcount + 32'd1;
  end
`endif

endmodule

// File: doc/dcache_data_store.md
# dcache_data_store

Parametrised set-associative data store and access controller for the data cache, sitting between the datapath's dREN/dWEN request port and the memory arbiter. Generalises the single-configuration access logic to configurable ways, sets and words per block. Adds multi-word refill, dirty-victim writeback through a write buffer, round-robin replacement, and a halt-time flush with completion flag.

## Interface
- WAYS, 2, associativity; power of two, ≥1
- SETS, 8, sets per way; power of two, ≥2
- WORDS, 2, 32-bit words per block; power of two, ≥1
- CLK  in  1  clock, rising-edge
- RST  in  1  synchronous reset, active-high
- dREN  in  1  datapath read request
- dWEN  in  1  datapath write request; never high together with dREN
- daddr  in  32  request byte address, word aligned
- dstore  in  32  write data
- halt  in  1  start flush; level, held until flushed
- dwait  in  1  memory busy; a fill word is taken in a cycle with dmissREN=1 and dwait=0
- dload  in  32  memory read data
- full  in  1  write buffer full; a writeback word is accepted in a cycle with ddirtyWEN=1 and full=0
- hit  out  1  request serviced this cycle
- ddata  out  32  read data, valid when hit=1 and dREN=1
- dmissREN  out  1  fill read request
- rdaddr  out  32  fill word address
- ddirtyWEN  out  1  writeback push
- ddirtyaddr  out  32  writeback word address
- ddirtydata  out  32  writeback word data
- flushed  out  1  flush complete

## Operation
- Address split: byte offset [1:0], word offset log2(WORDS) bits, index log2(SETS) bits, tag = remaining upper bits.
- Per line: valid, dirty, tag, WORDS data words. Per set: victim pointer, log2(WAYS) bits.
- States: IDLE, WB, FILL, FLUSH, HALTED.
- IDLE: a tag compare across all ways is combinational. A match with a valid line gives hit=1. Read: ddata = matched word. Write: word = dstore and dirty=1 at the next edge. No request gives hit=0.
- Miss in IDLE: the victim is the lowest-numbered invalid way; if every way is valid, the victim is the pointer. If the victim is valid and dirty, go to WB, otherwise go to FILL.
- WB: push victim words 0..WORDS-1 at addresses {victim tag, index, k, 00}. Advance k only on an accepted word. After the last word, go to FILL.
- FILL: dmissREN=1, rdaddr = {req tag, index, k, 00}. Write dload to word k when dwait=0. After the last word, the line becomes valid with dirty=0 and the new tag, the set's pointer increments mod WAYS, and the state returns to IDLE. The held request then hits.
- halt has priority in IDLE, including over a simultaneous request: go to FLUSH.
- FLUSH: scan sets 0..SETS-1 and, within each set, ways 0..WAYS-1. A clean or invalid line costs one cycle. A dirty line pushes WORDS words as in WB and then clears dirty. After the last line, go to HALTED.
- HALTED: flushed=1 until RST. dREN and dWEN are ignored in FLUSH and HALTED.
- The request must stay stable until hit; a change mid-miss is a protocol violation.

## Timing
- Reset: state IDLE; every valid, dirty and pointer cleared; all outputs 0.
- Hit latency: 0 cycles, combinational in the request cycle.
- Clean miss: WORDS accepted fill words, plus 1 cycle to hit.
- Dirty miss: WORDS accepted pushes, plus clean-miss cost.
- full or dwait held high stalls indefinitely. ddirtyaddr, ddirtydata and rdaddr stay stable during a stall.
- RST in any state takes effect at the next edge and abandons any WB, FILL or FLUSH in progress.

## Configuration
- DS_HIT_COUNTER_EN defined: adds output hitcount [31:0]. It counts IDLE cycles with hit=1, resets to 0, wraps at 2^32-1→0, and freezes in HALTED.
- Undefined: no port and no counter logic.

## Test plan
Defaults apply. 0x100 and 0x104 → index 0, tag 4. 0x200 → index 0, tag 8. 0x300 → index 0, tag 12.
- Cold read of 0x100, dload 0xAAAA0000 then 0xAAAA0004, dwait low → rdaddr 0x100 then 0x104 with dmissREN=1, then hit=1 and ddata=0xAAAA0000 three cycles after the request.
- Write 0x104 with dstore 0x12345678 → hit in the same cycle. A following read of 0x104 returns 0x12345678 with no dmissREN.
- Fill 0x200 into way 1, then read 0x300 → way 0 is the dirty victim. Pushes are (0x100, 0xAAAA0000) and (0x104, 0x12345678), then a fill from 0x300.
- full high for 3 cycles during WB → ddirtyWEN stays 1, ddirtyaddr stays 0x100 throughout, and word 1 is pushed only after full drops.
- Two dirty lines, then halt=1 with dREN=1 → exactly 4 pushes, no hit, flushed=1 thereafter, and a re-read of a flushed address misses nothing (the line stays valid and clean).
- RST during FILL word 1 → dmissREN=0 next cycle; a re-read of 0x100 misses.
